// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x XLEN register file with NRD combinational read ports,
// two write ports (port 1 wins), write-through bypass, per-register busy
// scoreboard and a power-up sequence that zeroes the array one entry per cycle.
module regfile_bypass #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*IDXW-1:0]  ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we0,
  input  logic [IDXW-1:0]      wa0,
  input  logic [XLEN-1:0]      wd0,
  input  logic                 we1,
  input  logic [IDXW-1:0]      wa1,
  input  logic [XLEN-1:0]      wd1,
  input  logic                 iss_valid,
  input  logic [IDXW-1:0]      iss_rd,
  input  logic [IDXW-1:0]      reg_sel,
  output logic [XLEN-1:0]      reg_data,
  output logic                 ready
);

  typedef enum logic {INIT, READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDXW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]   r_rf [NREG];
  logic [NREG-1:0]   r_busy;
  logic              w_ready;
  logic              w_we0, w_we1;

  assign w_ready = (r_state == READY);
  // Commits only once initialised; index 0 is hard-wired and never stored.
  assign w_we0   = w_ready && we0 && (wa0 != '0);
  assign w_we1   = w_ready && we1 && (wa1 != '0);
  assign ready   = w_ready;

  // State and init counter; reset restarts the clearing sweep at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: sweep every index once, then park in READY (cnt holds at top).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        if (r_cnt == IDXW'(NREG - 1)) w_state_nxt = READY;
        else                          w_cnt_nxt   = r_cnt + IDXW'(1);
      end
      READY: ;
      default: w_state_nxt = INIT;
    endcase
  end

  // Array storage: zeroing sweep in INIT, otherwise port 0 then port 1 so wd1 wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_ready) begin
        r_rf[r_cnt] <= '0;
      end else begin
        if (w_we0) r_rf[wa0] <= wd0;
        if (w_we1) r_rf[wa1] <= wd1;
      end
    end
  end

  // Busy scoreboard: a new issue beats a same-edge completing write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else if (w_ready) begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_valid && iss_rd == IDXW'(i))
          r_busy[i] <= 1'b1;
        else if ((w_we0 && wa0 == IDXW'(i)) || (w_we1 && wa1 == IDXW'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  // Read ports with write-through bypass; everything reads 0 until initialised.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDXW-1:0] w_a;
    logic            w_hit0, w_hit1;
    assign w_a    = ra[k*IDXW +: IDXW];
    assign w_hit1 = we1 && (wa1 == w_a);
    assign w_hit0 = we0 && (wa0 == w_a);
    assign rd[k*XLEN +: XLEN] = (!w_ready || w_a == '0) ? '0   :
                                w_hit1                  ? wd1  :
                                w_hit0                  ? wd0  : r_rf[w_a];
    assign rbusy[k] = w_ready && (w_a != '0) && r_busy[w_a] && !(w_hit0 || w_hit1);
  end

  // Debug port sees stored contents only.
  assign reg_data = (w_ready && reg_sel != '0) ? r_rf[reg_sel] : '0;

endmodule

// File: tb/tb_regfile_bypass.sv
// Randomised scoreboard bench for regfile_bypass: the driver pushes the
// reference model's expected outputs per cycle, a monitor pops and compares.
module tb_regfile_bypass;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int IDXW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*IDXW-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                we0, we1, iss_valid;
  logic [IDXW-1:0]     wa0, wa1, iss_rd, reg_sel;
  logic [XLEN-1:0]     wd0, wd1, reg_data;
  logic                ready;

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .reg_sel(reg_sel),
    .reg_data(reg_data), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic [XLEN-1:0]     reg_data;
    logic                ready;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: architectural state only.
  logic [XLEN-1:0] m_rf [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_cnt;

  function automatic void m_reset();
    m_ready = 0;
    m_cnt   = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.rd = '0; e.rbusy = '0; e.reg_data = '0; e.ready = m_ready;
    if (m_ready) begin
      for (int k = 0; k < NRD; k++) begin
        int a;
        logic [XLEN-1:0] v;
        bit wr;
        a  = int'(ra[k*IDXW +: IDXW]);
        wr = (we0 && int'(wa0) == a) || (we1 && int'(wa1) == a);
        if (a == 0)                         v = '0;
        else if (we1 && int'(wa1) == a)     v = wd1;
        else if (we0 && int'(wa0) == a)     v = wd0;
        else                                v = m_rf[a];
        e.rd[k*XLEN +: XLEN] = v;
        e.rbusy[k] = (a != 0) && m_busy[a] && !wr;
      end
      e.reg_data = (reg_sel == 0) ? '0 : m_rf[reg_sel];
    end
    return e;
  endfunction

  function automatic void m_edge();
    if (!m_ready) begin
      if (m_cnt == NREG - 1) begin
        m_ready = 1;
        foreach (m_rf[i]) m_rf[i] = '0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (we0 && wa0 != 0) m_rf[wa0] = wd0;
      if (we1 && wa1 != 0) m_rf[wa1] = wd1;
      if (we0) m_busy[wa0] = 0;
      if (we1) m_busy[wa1] = 0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
    end
  endfunction

  // One cycle: record expectation for current inputs, then advance the model.
  task automatic step();
    if (reset) m_reset();
    q.push_back(model_out());
    @(posedge clk);
    if (reset) m_reset(); else m_edge();
    #1;
  endtask

  task automatic idle();
    ra = '0; we0 = 0; wa0 = '0; wd0 = '0; we1 = 0; wa1 = '0; wd1 = '0;
    iss_valid = 0; iss_rd = '0; reg_sel = '0;
  endtask

  function automatic logic [IDXW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return IDXW'($urandom_range(0, NREG - 1));
    return IDXW'($urandom_range(0, 7));
  endfunction

  task automatic rand_in();
    for (int k = 0; k < NRD; k++) ra[k*IDXW +: IDXW] = raddr();
    we0 = 1'($urandom_range(0, 1)); wa0 = raddr(); wd0 = XLEN'($urandom);
    we1 = 1'($urandom_range(0, 1)); wa1 = raddr(); wd1 = XLEN'($urandom);
    iss_valid = 1'($urandom_range(0, 1)); iss_rd = raddr();
    reg_sel = raddr();
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled mid-cycle against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready",    128'(ready),    128'(e.ready));
      chk("rd",       128'(rd),       128'(e.rd));
      chk("rbusy",    128'(rbusy),    128'(e.rbusy));
      chk("reg_data", 128'(reg_data), 128'(e.reg_data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    m_reset();
    @(posedge clk); #1;
    repeat (3) step();
    // Release, then attempt writes/issues during INIT and pulse reset at cycle 10.
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_in(); we0 = 1; wa0 = 3; wd0 = 32'hDEAD_BEEF;
      step();
    end
    reset = 1'b1; step();
    reset = 1'b0;
    for (int c = 0; c < NREG; c++) begin
      rand_in(); we1 = 1; wa1 = 3; wd1 = 32'hCAFE_F00D;
      step();
    end
    // Sweep debug port: every register must read zero after INIT.
    idle();
    for (int i = 0; i < NREG; i++) begin
      reg_sel = IDXW'(i); ra[0 +: IDXW] = IDXW'(i); step();
    end
    // Single write with same-cycle bypass, then stored value.
    idle(); we0 = 1; wa0 = 5; wd0 = 32'h1234; ra[0 +: IDXW] = 5; step();
    idle(); reg_sel = 5; ra[IDXW +: IDXW] = 5; step();
    // Dual write collision: port 1 wins.
    idle(); we0 = 1; wa0 = 7; wd0 = 32'hAAAA; we1 = 1; wa1 = 7; wd1 = 32'h5555;
    ra[0 +: IDXW] = 7; step();
    idle(); reg_sel = 7; ra[0 +: IDXW] = 7; step();
    // Busy lifecycle on register 9.
    idle(); iss_valid = 1; iss_rd = 9; step();
    idle(); ra[IDXW +: IDXW] = 9; step();
    idle(); ra[IDXW +: IDXW] = 9; we1 = 1; wa1 = 9; wd1 = 32'h99; step();
    idle(); ra[IDXW +: IDXW] = 9; step();
    idle(); ra[IDXW +: IDXW] = 9; iss_valid = 1; iss_rd = 9; we1 = 1; wa1 = 9; wd1 = 32'h77; step();
    idle(); ra[IDXW +: IDXW] = 9; step();
    // Register 0 is immune to writes and issues.
    idle(); we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFF;
    iss_valid = 1; iss_rd = 0; step();
    idle(); reg_sel = 0; step();
    // Random traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      rand_in();
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, >=4); IDXW = log2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2, meaning read-port count (1..4).
REQ-004 The block SHALL have these ports, in this order (one per line: name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  ra  in  NRD*IDXW  read addresses, port k at bits [k*IDXW +: IDXW]
  rd  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
  rbusy  out  NRD  port k source register has a pending producer
  we0, wa0, wd0  in  1/IDXW/XLEN  write port 0
  we1, wa1, wd1  in  1/IDXW/XLEN  write port 1 (higher priority)
  iss_valid, iss_rd  in  1/IDXW  issue: mark destination busy
  reg_sel  in  IDXW  debug read address
  reg_data  out  XLEN  debug read data (no bypass)
  ready  out  1  initialisation complete

Function
REQ-005 Register 0 SHALL read as 0 on every port; writes and issues to index 0 SHALL be ignored.
REQ-006 Writes SHALL commit on the rising clk edge; when both ports are enabled to the same nonzero address, wd1 SHALL be stored.
REQ-007 Reads SHALL be combinational with write-through bypass; priority per port: ra==0 -> 0; we1&&wa1==ra -> wd1; we0&&wa0==ra -> wd0; else array contents.
REQ-008 reg_data SHALL return array contents only (0 for reg_sel==0), without bypass.
REQ-009 A busy bit per register SHALL be set at the edge where iss_valid=1 for iss_rd, and cleared at the edge where any enabled write port targets that register.
REQ-010 Simultaneous issue and write to the same register SHALL leave the bit set (the new producer wins).
REQ-011 rbusy[k] SHALL be busy[ra_k] AND NOT (a same-cycle enabled write to ra_k); it SHALL be 0 when ra_k==0.
REQ-012 The FSM SHALL have two states, INIT and READY; a counter cnt (IDXW bits) SHALL be used in INIT.
REQ-013 In INIT, each cycle SHALL write 0 to rf[cnt] and increment cnt; after writing index NREG-1, the state SHALL move to READY on the next edge, with no wrap beyond NREG-1.
REQ-014 In INIT, the block SHALL ignore we0, we1 and iss_valid; rd, reg_data and rbusy SHALL be 0.
REQ-015 ready SHALL be 1 exactly in READY, first asserting NREG rising edges after reset deasserts.

Reset
REQ-016 Asserting reset at any time SHALL force state INIT, cnt=0, all busy bits 0 and ready=0 immediately, without waiting for clk.
REQ-017 Reset asserted mid-INIT SHALL restart the clearing sequence from index 0.
REQ-018 Array contents SHALL NOT be cleared by reset itself, only by the INIT sequence.

Verification
REQ-019 Release reset, NREG=32 -> ready=0 for 32 edges, then 1; every reg_data reads 0.
REQ-020 When ready, we0=1, wa0=5, wd0=0x1234, ra0=5 in the same cycle -> rd port 0 = 0x1234 combinationally; after the edge, reg_sel=5 gives 0x1234.
REQ-021 we0 (wa0=7, wd0=0xAAAA) and we1 (wa1=7, wd1=0x5555) in the same cycle -> bypass and stored value = 0x5555.
REQ-022 iss_valid with iss_rd=9, then ra1=9 -> rbusy[1]=1; next, we1 to 9 -> rbusy[1]=0 that cycle, busy clear after the edge; issue and write to 9 on the same edge -> busy stays 1.
REQ-023 Write to 0 with wd=0xFFFF and iss_rd=0 -> rd=0, rbusy=0, reg_data(0)=0.
REQ-024 Pulse reset at INIT cycle 10, with a write attempted during INIT -> ready rises 32 edges after the second release; the written register reads 0.
